// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one FPAA island: address settle, inject/tunnel pulse train, release, status response.
// All outputs are registered; DONE holds the response until rsp_ready, and cmd_ready is high only in IDLE.
module fg_prog_sequencer #(
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 6,
    parameter int NUM_ROWS   = 10,
    parameter int NUM_COLS   = 22,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 16,
    parameter int GAP_CYC    = 8,
    parameter int TUN_CYC    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic                abort,
    output logic [ROW_BITS-1:0] row_addr,
    output logic [COL_BITS-1:0] col_addr,
    output logic                prog_en,
    output logic                drain_en,
    output logic                vinj_pulse,
    output logic                tun_en,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_err,
    output logic                rsp_aborted,
    output logic [CNT_W-1:0]    rsp_pulses
);

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, GAP, TUNNEL, RELEASE, DONE, ERR
    } state_t;

    localparam int MAX_A   = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int MAX_B   = (GAP_CYC > TUN_CYC) ? GAP_CYC : TUN_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TUN_LAST    = TMR_W'(TUN_CYC - 1);
    localparam logic [31:0]      NUM_ROWS_U  = 32'(NUM_ROWS);
    localparam logic [31:0]      NUM_COLS_U  = 32'(NUM_COLS);

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic                op_q, op_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                aborted_q, aborted_d;
    logic                err_q, err_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
    logic [COL_BITS-1:0] col_addr_q, col_addr_d;
    logic                prog_en_q, prog_en_d;
    logic                drain_en_q, drain_en_d;
    logic                vinj_pulse_q, vinj_pulse_d;
    logic                tun_en_q, tun_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_aborted_q, rsp_aborted_d;
    logic [CNT_W-1:0]    rsp_pulses_q, rsp_pulses_d;

    logic                out_of_range;

    assign out_of_range = (32'(cmd_row) >= NUM_ROWS_U) || (32'(cmd_col) >= NUM_COLS_U);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        pulse_cnt_d = pulse_cnt_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        count_d     = count_q;
        aborted_d   = aborted_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    row_d       = cmd_row;
                    col_d       = cmd_col;
                    count_d     = cmd_count;
                    pulse_cnt_d = '0;
                    aborted_d   = 1'b0;
                    err_d       = out_of_range;
                    state_d     = out_of_range ? ERR : SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = RELEASE;
                end else if (timer_q == SETTLE_LAST) begin
                    if (op_q)                 state_d = TUNNEL;
                    else if (count_q != '0)   state_d = PULSE;
                    else                      state_d = RELEASE;
                end
            end
            PULSE: begin
                // An aborted pulse is cut short and never counted.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = RELEASE;
                end else if (timer_q == PULSE_LAST) begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                    state_d     = (pulse_cnt_d == count_q) ? RELEASE : GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = RELEASE;
                end else if (timer_q == GAP_LAST) begin
                    state_d = PULSE;
                end
            end
            TUNNEL: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = RELEASE;
                end else if (timer_q == TUN_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (timer_q == SETTLE_LAST) state_d = DONE;
            end
            DONE: begin
                if (rsp_valid_q && rsp_ready) state_d = IDLE;
            end
            ERR: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q || state_q == IDLE || state_q == DONE || state_q == ERR) begin
            timer_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register in the same cycle the state does.
    always_comb begin
        cmd_ready_d   = (state_d == IDLE);
        row_addr_d    = '0;
        col_addr_d    = '0;
        prog_en_d     = 1'b0;
        drain_en_d    = 1'b0;
        vinj_pulse_d  = 1'b0;
        tun_en_d      = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_aborted_d = 1'b0;
        rsp_pulses_d  = '0;

        case (state_d)
            SETUP, PULSE, GAP, TUNNEL, RELEASE: begin
                row_addr_d   = row_d;
                col_addr_d   = col_d;
                prog_en_d    = 1'b1;
                drain_en_d   = !op_d && (state_d != RELEASE);
                vinj_pulse_d = (state_d == PULSE);
                tun_en_d     = (state_d == TUNNEL);
            end
            DONE: begin
                rsp_valid_d   = 1'b1;
                rsp_err_d     = err_d;
                rsp_aborted_d = aborted_d;
                rsp_pulses_d  = op_d ? '0 : pulse_cnt_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            pulse_cnt_q   <= '0;
            op_q          <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            count_q       <= '0;
            aborted_q     <= 1'b0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            row_addr_q    <= '0;
            col_addr_q    <= '0;
            prog_en_q     <= 1'b0;
            drain_en_q    <= 1'b0;
            vinj_pulse_q  <= 1'b0;
            tun_en_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_aborted_q <= 1'b0;
            rsp_pulses_q  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pulse_cnt_q   <= pulse_cnt_d;
            op_q          <= op_d;
            row_q         <= row_d;
            col_q         <= col_d;
            count_q       <= count_d;
            aborted_q     <= aborted_d;
            err_q         <= err_d;
            cmd_ready_q   <= cmd_ready_d;
            row_addr_q    <= row_addr_d;
            col_addr_q    <= col_addr_d;
            prog_en_q     <= prog_en_d;
            drain_en_q    <= drain_en_d;
            vinj_pulse_q  <= vinj_pulse_d;
            tun_en_q      <= tun_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_aborted_q <= rsp_aborted_d;
            rsp_pulses_q  <= rsp_pulses_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign row_addr    = row_addr_q;
    assign col_addr    = col_addr_q;
    assign prog_en     = prog_en_q;
    assign drain_en    = drain_en_q;
    assign vinj_pulse  = vinj_pulse_q;
    assign tun_en      = tun_en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_aborted = rsp_aborted_q;
    assign rsp_pulses  = rsp_pulses_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: per-cycle waveform tracking plus a response scoreboard.
module tb_fg_prog_sequencer;

    localparam int ROW_BITS = 6;
    localparam int COL_BITS = 6;
    localparam int CNT_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_op;
    logic [ROW_BITS-1:0] cmd_row, row_addr;
    logic [COL_BITS-1:0] cmd_col, col_addr;
    logic [CNT_W-1:0]    cmd_count, rsp_pulses;
    logic                abort, prog_en, drain_en, vinj_pulse, tun_en;
    logic                rsp_valid, rsp_ready, rsp_err, rsp_aborted;

    always #5 clk = ~clk;

    fg_prog_sequencer #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .NUM_ROWS(10), .NUM_COLS(22),
        .CNT_W(CNT_W), .SETTLE_CYC(4), .PULSE_CYC(16), .GAP_CYC(8), .TUN_CYC(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_count(cmd_count),
        .abort(abort),
        .row_addr(row_addr), .col_addr(col_addr), .prog_en(prog_en),
        .drain_en(drain_en), .vinj_pulse(vinj_pulse), .tun_en(tun_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_aborted(rsp_aborted), .rsp_pulses(rsp_pulses)
    );

    typedef struct {
        logic       err;
        logic       aborted;
        logic [7:0] pulses;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   lat, first_vinj, vinj_runs, vinj_high, vinj_last, run_min, run_max;
    int   first_tun, tun_high, rel_cnt;
    bit   prog_seen, drain_seen, overlap;
    logic [ROW_BITS-1:0] row1;
    logic [COL_BITS-1:0] col1;
    logic prog1, drain1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic e, input logic a, input logic [7:0] p, input int l);
        exp_t x;
        x.err = e; x.aborted = a; x.pulses = p; x.lat = l;
        sb_q.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1 after the accept edge T.
    task automatic accept(input logic op, input logic [5:0] row, input logic [5:0] col,
                          input logic [7:0] cnt);
        int n = 0;
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_count = cnt; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'b0, cmd_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic track(input int abort_at);
        int   k = 1;
        int   cur = 0;
        logic pv = 1'b0;
        first_vinj = -1; vinj_runs = 0; vinj_high = 0; vinj_last = -1;
        run_min = 1000; run_max = 0; first_tun = -1; tun_high = 0; rel_cnt = 0;
        prog_seen = 0; drain_seen = 0; overlap = 0;
        row1 = row_addr; col1 = col_addr; prog1 = prog_en; drain1 = drain_en;
        while (!rsp_valid && k < 300) begin
            if (vinj_pulse) begin
                vinj_high++;
                vinj_last = k;
                if (first_vinj < 0) first_vinj = k;
                if (!pv) vinj_runs++;
                cur++;
            end else if (pv) begin
                if (cur < run_min) run_min = cur;
                if (cur > run_max) run_max = cur;
                cur = 0;
            end
            pv = vinj_pulse;
            if (tun_en) begin
                tun_high++;
                if (first_tun < 0) first_tun = k;
            end
            if (prog_en) prog_seen = 1;
            if (drain_en) drain_seen = 1;
            if (vinj_pulse && tun_en) overlap = 1;
            if (prog_en && !drain_en && !vinj_pulse && !tun_en) rel_cnt++;
            abort = (k == abort_at);
            @(negedge clk);
            k++;
        end
        abort = 1'b0;
        lat = k;
    endtask

    task automatic respond(input int hold, input bit present);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        chk("latency", lat, e.lat);
        chk("done_valid", {31'b0, rsp_valid}, 1);
        chk("done_row", {26'b0, row_addr}, 0);
        chk("done_col", {26'b0, col_addr}, 0);
        chk("done_prog", {31'b0, prog_en}, 0);
        if (present) begin
            cmd_op = 1'b0; cmd_row = 6'd0; cmd_col = 6'd22; cmd_count = 8'd1; cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'b0, rsp_valid}, 1);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("hold_aborted", {31'b0, rsp_aborted}, {31'b0, e.aborted});
            chk("hold_pulses", {24'b0, rsp_pulses}, {24'b0, e.pulses});
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_aborted", {31'b0, rsp_aborted}, {31'b0, e.aborted});
        chk("rsp_pulses", {24'b0, rsp_pulses}, {24'b0, e.pulses});
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", {31'b0, rsp_valid}, 0);
        chk("post_hs_cmd_ready", {31'b0, cmd_ready}, 1);
        if (present) begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("done_cmd_accepted", {31'b0, cmd_ready}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0; cmd_col = '0;
        cmd_count = '0; abort = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_prog", {31'b0, prog_en}, 0);
        chk("rst_vinj", {31'b0, vinj_pulse}, 0);
        chk("rst_tun", {31'b0, tun_en}, 0);
        chk("rst_row", {26'b0, row_addr}, 0);
        rst = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ignored", {31'b0, cmd_ready}, 1);

        // Inject 3 pulses, back-pressured, with an out-of-range command waiting during DONE.
        push_exp(1'b0, 1'b0, 8'd3, 73);
        accept(1'b0, 6'd2, 6'd5, 8'd3);
        track(-1);
        chk("inj_row", {26'b0, row1}, 2);
        chk("inj_col", {26'b0, col1}, 5);
        chk("inj_prog_t1", {31'b0, prog1}, 1);
        chk("inj_drain_t1", {31'b0, drain1}, 1);
        chk("inj_first_rise", first_vinj, 5);
        chk("inj_runs", vinj_runs, 3);
        chk("inj_high", vinj_high, 48);
        chk("inj_run_min", run_min, 16);
        chk("inj_run_max", run_max, 16);
        chk("inj_last", vinj_last, 68);
        chk("inj_release", rel_cnt, 4);
        chk("inj_tun", tun_high, 0);
        chk("inj_overlap", {31'b0, overlap}, 0);
        push_exp(1'b1, 1'b0, 8'd0, 2);
        respond(10, 1'b1);

        // Out-of-range column 22 (accepted inside respond above).
        track(-1);
        chk("err_prog_seen", {31'b0, prog_seen}, 0);
        chk("err_vinj", vinj_high, 0);
        respond(0, 1'b0);

        // Erase at the last legal row/column.
        push_exp(1'b0, 1'b0, 8'd0, 73);
        accept(1'b1, 6'd9, 6'd21, 8'd7);
        track(-1);
        chk("ers_row", {26'b0, row1}, 9);
        chk("ers_col", {26'b0, col1}, 21);
        chk("ers_prog_t1", {31'b0, prog1}, 1);
        chk("ers_first_tun", first_tun, 5);
        chk("ers_tun_high", tun_high, 64);
        chk("ers_drain_seen", {31'b0, drain_seen}, 0);
        chk("ers_vinj", vinj_high, 0);
        chk("ers_overlap", {31'b0, overlap}, 0);
        chk("ers_low_drain_cycles", rel_cnt, 8);
        respond(0, 1'b0);

        // Abort 3 cycles into the second pulse of a 5-pulse inject.
        push_exp(1'b0, 1'b1, 8'd1, 36);
        accept(1'b0, 6'd1, 6'd1, 8'd5);
        track(31);
        chk("abt_runs", vinj_runs, 2);
        chk("abt_last", vinj_last, 31);
        chk("abt_run_min", run_min, 3);
        chk("abt_run_max", run_max, 16);
        chk("abt_release", rel_cnt, 4);
        respond(2, 1'b0);

        // Zero-count inject; abort during RELEASE is ignored.
        push_exp(1'b0, 1'b0, 8'd0, 9);
        accept(1'b0, 6'd0, 6'd0, 8'd0);
        track(6);
        chk("zero_vinj", vinj_high, 0);
        chk("zero_release", rel_cnt, 4);
        respond(0, 1'b0);

        // Row 10 is out of range.
        push_exp(1'b1, 1'b0, 8'd0, 2);
        accept(1'b0, 6'd10, 6'd0, 8'd4);
        track(-1);
        chk("row_err_prog_seen", {31'b0, prog_seen}, 0);
        respond(0, 1'b0);

        // Asynchronous reset in the middle of a pulse.
        accept(1'b0, 6'd3, 6'd4, 8'd2);
        repeat (9) @(negedge clk);
        chk("pre_rst_vinj", {31'b0, vinj_pulse}, 1);
        chk("pre_rst_prog", {31'b0, prog_en}, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vinj", {31'b0, vinj_pulse}, 0);
        chk("arst_prog", {31'b0, prog_en}, 0);
        chk("arst_drain", {31'b0, drain_en}, 0);
        chk("arst_row", {26'b0, row_addr}, 0);
        chk("arst_cmd_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);

        // Single-pulse inject after reset confirms the pulse counter restarted.
        push_exp(1'b0, 1'b0, 8'd1, 25);
        accept(1'b0, 6'd3, 6'd4, 8'd1);
        track(-1);
        chk("one_runs", vinj_runs, 1);
        chk("one_first_rise", first_vinj, 5);
        respond(0, 1'b0);

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
- Programming controller for one FPAA island's floating-gate switch matrix.
- Sits directly upstream of the island programming mux. It drives:
  - the horizontal decoder (column address);
  - the vertical decoder (row address);
  - the drain-select and programming-switch enables;
  - the injection and tunnelling pulse lines.
- Accepts one command per transaction (inject N pulses, or erase). It sequences address settle, pulse train and release, then returns a status response.

Parameters:
- ROW_BITS, 6, width of row address to vertical decoder
- COL_BITS, 6, width of column address to horizontal decoder
- NUM_ROWS, 10, legal rows 0..NUM_ROWS-1
- NUM_COLS, 22, legal columns 0..NUM_COLS-1
- CNT_W, 8, width of pulse count and pulse counters
- SETTLE_CYC, 4, cycles for address/enable settle and for release (>=1)
- PULSE_CYC, 16, cycles each injection pulse is high (>=1)
- GAP_CYC, 8, low cycles between consecutive pulses (>=1)
- TUN_CYC, 64, cycles of tunnelling pulse for erase (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept command
- cmd_op  in  1  0=inject, 1=erase
- cmd_row  in  ROW_BITS  target row
- cmd_col  in  COL_BITS  target column
- cmd_count  in  CNT_W  number of injection pulses (ignored for erase)
- abort  in  1  terminate current operation
- row_addr  out  ROW_BITS  to vertical decoder
- col_addr  out  COL_BITS  to horizontal decoder
- prog_en  out  1  programming-switch select (run mode when 0)
- drain_en  out  1  drain-select enable
- vinj_pulse  out  1  injection pulse
- tun_en  out  1  tunnelling pulse
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_err  out  1  address out of range
- rsp_aborted  out  1  operation aborted
- rsp_pulses  out  CNT_W  pulses fully delivered

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE;
  - all outputs 0 except cmd_ready=1;
  - counters cleared.
  - A reset mid-pulse drops vinj_pulse/tun_en immediately, with no release phase.
- All outputs are registered.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid&&cmd_ready at edge T, and all command fields are latched at T.
- IDLE → ERR if cmd_row>=NUM_ROWS or cmd_col>=NUM_COLS.
  - ERR lasts 1 cycle with prog_en=0, then DONE with rsp_err=1, rsp_pulses=0.
- IDLE → SETUP otherwise. From T+1:
  - row_addr/col_addr are driven;
  - prog_en=1;
  - drain_en=1 for inject, drain_en=0 for erase.
  - SETUP lasts SETTLE_CYC cycles.
- SETUP exit:
  - inject with count>0 → PULSE;
  - inject with count=0 → RELEASE;
  - erase → TUNNEL.
- PULSE:
  - vinj_pulse=1 for PULSE_CYC cycles.
  - At the end, the pulse counter increments.
  - If the counter equals the count → RELEASE, else → GAP.
  - No GAP follows the last pulse.
- GAP: vinj_pulse=0 for GAP_CYC cycles, then → PULSE.
- TUNNEL: tun_en=1 for TUN_CYC cycles, then → RELEASE. rsp_pulses=0 for erase.
- RELEASE:
  - vinj_pulse=tun_en=drain_en=0;
  - addresses and prog_en are held;
  - lasts SETTLE_CYC cycles, then → DONE.
- DONE:
  - addresses=0, prog_en=0;
  - rsp_valid=1 with fields stable until rsp_ready;
  - on rsp_valid&&rsp_ready → IDLE.
- Inject latency, accept edge T to first rsp_valid cycle: 1+SETTLE+N*PULSE+(N-1)*GAP+SETTLE. With defaults and N=3 this is T+73.
- abort:
  - Sampled in SETUP/PULSE/GAP/TUNNEL: the next state is RELEASE and rsp_aborted=1.
  - An interrupted pulse is not counted.
  - abort in IDLE, ERR, RELEASE or DONE is ignored. In RELEASE the operation completes normally with rsp_aborted=0.
- Counter saturation: not required, since count<=2^CNT_W-1 and the pulse counter is CNT_W wide.
- vinj_pulse and tun_en are never 1 simultaneously.
- prog_en=0 whenever vinj_pulse or tun_en could toggle outside SETUP..RELEASE.

Test Plan:
- Inject row=2, col=5, count=3, defaults:
  - row_addr=2, col_addr=5 and prog_en=1 from T+1;
  - vinj high in 3 runs of 16 separated by 8 low cycles;
  - first rise at T+5;
  - rsp_valid at T+73 with rsp_pulses=3, err=0, aborted=0.
- Out-of-range col=22:
  - prog_en is never 1;
  - rsp_valid at T+2 with rsp_err=1, rsp_pulses=0.
- Erase row=9, col=21:
  - tun_en high for exactly 64 cycles starting T+5;
  - drain_en=0 and vinj=0 throughout;
  - rsp_valid at T+73.
- Inject count=5, abort pulsed 3 cycles into the 2nd pulse:
  - vinj drops the next cycle;
  - RELEASE lasts 4 cycles;
  - rsp_aborted=1, rsp_pulses=1.
- Back-pressure:
  - with rsp_ready=0 for 10 cycles, rsp fields are held and cmd_ready=0;
  - a command presented during DONE is not accepted until the cycle after the handshake.
- Inject count=0: no vinj pulse, rsp_valid at T+9 with rsp_pulses=0. In a separate run, rst asserted mid-PULSE clears all outputs asynchronously and cmd_ready=1 after release.
